id_ex_pipe_reg: RTL and testbench
=================================

# id_ex_pipe_reg

Parametrised ID/EX pipeline register for the 5-stage MIPS core, successor to the plain ID/EX latch. It adds hold (stall), bubble insertion (flush), a per-stage valid bit, and saturating stall/bubble performance counters, so the hazard-detection and branch units can drive it directly. It sits between the decode stage (register file, sign extender, main control) and the execute stage (ALU, forwarding unit).

## Interface
Parameters:
- DATA_W, 32, width of PC+4, both read-data and sign-extend fields
- REG_W, 5, register-index width (rs, rt, rd)
- ALUOP_W, 2, ALU-op control field width
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low; one clock, reset is asynchronous and active-low
- stall  in  1  hold all stage contents this cycle
- flush  in  1  load a bubble this cycle
- valid_in  in  1  decode stage holds a real instruction
- reg_write_in, mem_to_reg_in, branch_in, mem_read_in, mem_write_in, alu_src_in, reg_dst_in  in  1 each  control from main decoder
- alu_op_in  in  ALUOP_W  ALU-op control
- pc_4_in, rd_data_1_in, rd_data_2_in, sign_ext_in  in  DATA_W each  datapath operands
- rs_in, rt_in, rd_in  in  REG_W each  register indices
- cnt_clr  in  1  synchronous clear of both counters
- valid_out  out  1  execute stage holds a real instruction
- all *_out counterparts of the above  out  same widths
- stall_cnt  out  CNT_W  cycles spent in hold
- bubble_cnt  out  CNT_W  bubbles loaded

## Operation
- Per cycle, exactly one action, priority flush > stall > load.
- Load: every *_out <= *_in; valid_out <= valid_in. If valid_in=0, the seven 1-bit controls and alu_op_out are forced to 0 (gated bubble); data and index fields still load.
- Flush: all control outputs, alu_op_out, valid_out, rs/rt/rd_out, and all DATA_W fields <= 0. Zeroed indices guarantee the forwarding unit never matches a bubble (register $0).
- Stall: all stage outputs hold their value.
- stall_cnt: +1 on cycles where stall=1 and flush=0.
- bubble_cnt: +1 on cycles where flush=1, or a load occurs with valid_in=0.
- Counters saturate at 2^CNT_W-1 (no wrap). cnt_clr=1 forces 0 next edge, overriding any increment that cycle.
- Counters are independent of stage action; cnt_clr does not affect stage contents.

## Timing
- Latency: 1 cycle from *_in to *_out on load.
- All outputs are registers; no combinational path from input to output.
- Reset (rst=0): every output, including valid_out and both counters, goes to 0 immediately, without waiting for clk. Outputs stay 0 while rst=0. The first load occurs at the first rising edge after release.
- Reset mid-stall or mid-flush: reset wins. No state survives.
- stall=1 and flush=1 together: flush action taken. stall_cnt does not increment; bubble_cnt increments.
- Load-use hazard usage: the hazard unit asserts flush here and stalls PC and IF/ID in the same cycle. The resulting bubble carries mem_read_out=0 and reg_write_out=0.

## Structure
- Shared package pipeline_pkg:
  - ALUOP_W
  - ALU-op encodings (ALUOP_ADD=0, ALUOP_SUB=1, ALUOP_RTYPE=2)
  - typedef id_ex_ctrl_t, bundling the seven 1-bit controls plus alu_op, reused by the EX/MEM and MEM/WB successors
- One sub-module, sat_counter:
  - Parameter W
  - Ports clk, rst, inc, clr, count
  - Instantiated twice, for stall_cnt and bubble_cnt
  - Clear overrides increment; holds at max

## Test plan
- Reset: drive all inputs non-zero, pulse rst=0 between edges → every output reads 0 before the next clk edge. After release, the first edge loads pc_4_in=32'h0000_0004 to pc_4_out.
- Load with valid_in=1: reg_write_in=1, alu_op_in=2, rs/rt/rd_in=8/9/10, rd_data_1_in=32'hDEAD_BEEF → identical values on the outputs one cycle later, valid_out=1.
- Stall for 3 cycles while inputs change → outputs frozen at the pre-stall values, stall_cnt=3, bubble_cnt unchanged.
- Flush with stall=1 and mem_read_in=1 → next cycle all controls, rs/rt/rd_out and valid_out are 0; bubble_cnt +1; stall_cnt unchanged.
- Load with valid_in=0, reg_write_in=1, mem_write_in=1 → reg_write_out=0, mem_write_out=0, rd_data_2_out=rd_data_2_in, bubble_cnt +1.
- Counter saturation with CNT_W=4: hold stall for 20 cycles → stall_cnt=15. Then cnt_clr=1 with stall=1 → stall_cnt=0 next cycle.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared definitions for the MIPS pipeline registers (ID/EX, EX/MEM, MEM/WB).
package pipeline_pkg;

  localparam int ALUOP_W = 2;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'd0;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'd1;
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'd2;

  // Control bundle produced by the main decoder and carried down the pipe.
  typedef struct packed {
    logic               reg_write;
    logic               mem_to_reg;
    logic               branch;
    logic               mem_read;
    logic               mem_write;
    logic               alu_src;
    logic               reg_dst;
    logic [ALUOP_W-1:0] alu_op;
  } id_ex_ctrl_t;

  // A bubble never writes registers or memory.
  localparam id_ex_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_pipe_reg_sat_counter.sv
// Saturating event counter with synchronous clear; used for pipeline perf stats.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_d, count_q;

  // Clear wins over increment; increment stops at all-ones.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // Counter state, cleared asynchronously while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with hold, bubble insertion, valid bit and
// saturating stall/bubble counters. Action priority: flush > stall > load.
module id_ex_pipe_reg #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int ALUOP_W = pipeline_pkg::ALUOP_W,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               valid_in,
  input  logic               reg_write_in,
  input  logic               mem_to_reg_in,
  input  logic               branch_in,
  input  logic               mem_read_in,
  input  logic               mem_write_in,
  input  logic               alu_src_in,
  input  logic               reg_dst_in,
  input  logic [ALUOP_W-1:0] alu_op_in,
  input  logic [DATA_W-1:0]  pc_4_in,
  input  logic [DATA_W-1:0]  rd_data_1_in,
  input  logic [DATA_W-1:0]  rd_data_2_in,
  input  logic [DATA_W-1:0]  sign_ext_in,
  input  logic [REG_W-1:0]   rs_in,
  input  logic [REG_W-1:0]   rt_in,
  input  logic [REG_W-1:0]   rd_in,
  input  logic               cnt_clr,
  output logic               valid_out,
  output logic               reg_write_out,
  output logic               mem_to_reg_out,
  output logic               branch_out,
  output logic               mem_read_out,
  output logic               mem_write_out,
  output logic               alu_src_out,
  output logic               reg_dst_out,
  output logic [ALUOP_W-1:0] alu_op_out,
  output logic [DATA_W-1:0]  pc_4_out,
  output logic [DATA_W-1:0]  rd_data_1_out,
  output logic [DATA_W-1:0]  rd_data_2_out,
  output logic [DATA_W-1:0]  sign_ext_out,
  output logic [REG_W-1:0]   rs_out,
  output logic [REG_W-1:0]   rt_out,
  output logic [REG_W-1:0]   rd_out,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
);

  import pipeline_pkg::*;

  id_ex_ctrl_t       ctrl_in, ctrl_d, ctrl_q;
  logic              valid_d, valid_q;
  logic [DATA_W-1:0] pc_4_d, pc_4_q;
  logic [DATA_W-1:0] rd_data_1_d, rd_data_1_q;
  logic [DATA_W-1:0] rd_data_2_d, rd_data_2_q;
  logic [DATA_W-1:0] sign_ext_d, sign_ext_q;
  logic [REG_W-1:0]  rs_d, rs_q;
  logic [REG_W-1:0]  rt_d, rt_q;
  logic [REG_W-1:0]  rd_d, rd_q;
  logic              stall_inc, bubble_inc;

  // Bundle decoder controls; a non-valid decode slot is gated to a bubble.
  always_comb begin
    ctrl_in            = CTRL_BUBBLE;
    ctrl_in.reg_write  = reg_write_in;
    ctrl_in.mem_to_reg = mem_to_reg_in;
    ctrl_in.branch     = branch_in;
    ctrl_in.mem_read   = mem_read_in;
    ctrl_in.mem_write  = mem_write_in;
    ctrl_in.alu_src    = alu_src_in;
    ctrl_in.reg_dst    = reg_dst_in;
    ctrl_in.alu_op     = alu_op_in;
    if (!valid_in) begin
      ctrl_in = CTRL_BUBBLE;
    end
  end

  // Stage next-state: flush zeroes everything (indices too, so the
  // forwarding unit sees $0), stall holds, otherwise load from decode.
  always_comb begin
    ctrl_d      = ctrl_q;
    valid_d     = valid_q;
    pc_4_d      = pc_4_q;
    rd_data_1_d = rd_data_1_q;
    rd_data_2_d = rd_data_2_q;
    sign_ext_d  = sign_ext_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    rd_d        = rd_q;
    if (flush) begin
      ctrl_d      = CTRL_BUBBLE;
      valid_d     = 1'b0;
      pc_4_d      = '0;
      rd_data_1_d = '0;
      rd_data_2_d = '0;
      sign_ext_d  = '0;
      rs_d        = '0;
      rt_d        = '0;
      rd_d        = '0;
    end else if (!stall) begin
      ctrl_d      = ctrl_in;
      valid_d     = valid_in;
      pc_4_d      = pc_4_in;
      rd_data_1_d = rd_data_1_in;
      rd_data_2_d = rd_data_2_in;
      sign_ext_d  = sign_ext_in;
      rs_d        = rs_in;
      rt_d        = rt_in;
      rd_d        = rd_in;
    end
  end

  // Stage registers; everything clears asynchronously on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q      <= CTRL_BUBBLE;
      valid_q     <= 1'b0;
      pc_4_q      <= '0;
      rd_data_1_q <= '0;
      rd_data_2_q <= '0;
      sign_ext_q  <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      valid_q     <= valid_d;
      pc_4_q      <= pc_4_d;
      rd_data_1_q <= rd_data_1_d;
      rd_data_2_q <= rd_data_2_d;
      sign_ext_q  <= sign_ext_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
    end
  end

  // A hold cycle only counts when no flush overrides it; a bubble is either
  // a flush or a load of a non-valid decode slot.
  assign stall_inc  = stall & ~flush;
  assign bubble_inc = flush | (~stall & ~valid_in);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .clr   (cnt_clr),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bubble_inc),
    .clr   (cnt_clr),
    .count (bubble_cnt)
  );

  assign valid_out      = valid_q;
  assign reg_write_out  = ctrl_q.reg_write;
  assign mem_to_reg_out = ctrl_q.mem_to_reg;
  assign branch_out     = ctrl_q.branch;
  assign mem_read_out   = ctrl_q.mem_read;
  assign mem_write_out  = ctrl_q.mem_write;
  assign alu_src_out    = ctrl_q.alu_src;
  assign reg_dst_out    = ctrl_q.reg_dst;
  assign alu_op_out     = ctrl_q.alu_op;
  assign pc_4_out       = pc_4_q;
  assign rd_data_1_out  = rd_data_1_q;
  assign rd_data_2_out  = rd_data_2_q;
  assign sign_ext_out   = sign_ext_q;
  assign rs_out         = rs_q;
  assign rt_out         = rt_q;
  assign rd_out         = rd_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed scenarios plus random
// traffic compared against a behavioural model of the stage and counters.
module tb_id_ex_pipe_reg;

  localparam int DATA_W  = 32;
  localparam int REG_W   = 5;
  localparam int ALUOP_W = 2;
  localparam int CNT_W   = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               stall, flush, valid_in, cnt_clr;
  logic               reg_write_in, mem_to_reg_in, branch_in, mem_read_in;
  logic               mem_write_in, alu_src_in, reg_dst_in;
  logic [ALUOP_W-1:0] alu_op_in;
  logic [DATA_W-1:0]  pc_4_in, rd_data_1_in, rd_data_2_in, sign_ext_in;
  logic [REG_W-1:0]   rs_in, rt_in, rd_in;
  logic               valid_out;
  logic               reg_write_out, mem_to_reg_out, branch_out, mem_read_out;
  logic               mem_write_out, alu_src_out, reg_dst_out;
  logic [ALUOP_W-1:0] alu_op_out;
  logic [DATA_W-1:0]  pc_4_out, rd_data_1_out, rd_data_2_out, sign_ext_out;
  logic [REG_W-1:0]   rs_out, rt_out, rd_out;
  logic [CNT_W-1:0]   stall_cnt, bubble_cnt;

  id_ex_pipe_reg #(
    .DATA_W(DATA_W), .REG_W(REG_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
    .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
    .branch_in(branch_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .alu_src_in(alu_src_in),
    .reg_dst_in(reg_dst_in), .alu_op_in(alu_op_in),
    .pc_4_in(pc_4_in), .rd_data_1_in(rd_data_1_in),
    .rd_data_2_in(rd_data_2_in), .sign_ext_in(sign_ext_in),
    .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .cnt_clr(cnt_clr),
    .valid_out(valid_out), .reg_write_out(reg_write_out),
    .mem_to_reg_out(mem_to_reg_out), .branch_out(branch_out),
    .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .alu_src_out(alu_src_out), .reg_dst_out(reg_dst_out),
    .alu_op_out(alu_op_out), .pc_4_out(pc_4_out),
    .rd_data_1_out(rd_data_1_out), .rd_data_2_out(rd_data_2_out),
    .sign_ext_out(sign_ext_out), .rs_out(rs_out), .rt_out(rt_out),
    .rd_out(rd_out), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state (what the execute stage should hold).
  logic        m_valid;
  logic [8:0]  m_ctrl;
  logic [31:0] m_pc4, m_rd1, m_rd2, m_sext;
  logic [14:0] m_idx;
  int          m_scnt, m_bcnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [8:0] ctrl_in_vec();
    return {reg_write_in, mem_to_reg_in, branch_in, mem_read_in,
            mem_write_in, alu_src_in, reg_dst_in, alu_op_in};
  endfunction

  task automatic model_reset();
    m_valid = 0; m_ctrl = 0; m_pc4 = 0; m_rd1 = 0; m_rd2 = 0; m_sext = 0;
    m_idx = 0; m_scnt = 0; m_bcnt = 0;
  endtask

  // One clock edge worth of behaviour, from current inputs.
  task automatic model_edge();
    bit bubble_evt;
    bubble_evt = flush || (!stall && !valid_in);
    if (cnt_clr) begin
      m_scnt = 0;
      m_bcnt = 0;
    end else begin
      if (stall && !flush) m_scnt = (m_scnt + 1 > CMAX) ? CMAX : m_scnt + 1;
      if (bubble_evt)      m_bcnt = (m_bcnt + 1 > CMAX) ? CMAX : m_bcnt + 1;
    end
    if (flush) begin
      m_valid = 0; m_ctrl = 0; m_pc4 = 0; m_rd1 = 0; m_rd2 = 0; m_sext = 0;
      m_idx = 0;
    end else if (!stall) begin
      m_valid = valid_in;
      m_ctrl  = valid_in ? ctrl_in_vec() : 9'd0;
      m_pc4   = pc_4_in;
      m_rd1   = rd_data_1_in;
      m_rd2   = rd_data_2_in;
      m_sext  = sign_ext_in;
      m_idx   = {rs_in, rt_in, rd_in};
    end
  endtask

  task automatic check_all(input string pfx);
    check({pfx, ".valid"},  valid_out, m_valid);
    check({pfx, ".ctrl"},   {reg_write_out, mem_to_reg_out, branch_out, mem_read_out,
                             mem_write_out, alu_src_out, reg_dst_out, alu_op_out}, m_ctrl);
    check({pfx, ".pc_4"},   pc_4_out, m_pc4);
    check({pfx, ".rd1"},    rd_data_1_out, m_rd1);
    check({pfx, ".rd2"},    rd_data_2_out, m_rd2);
    check({pfx, ".sext"},   sign_ext_out, m_sext);
    check({pfx, ".idx"},    {rs_out, rt_out, rd_out}, m_idx);
    check({pfx, ".scnt"},   stall_cnt, m_scnt);
    check({pfx, ".bcnt"},   bubble_cnt, m_bcnt);
  endtask

  // Advance one edge, update the model, sample 1 time unit later.
  task automatic step(input string pfx);
    @(posedge clk);
    if (rst) model_edge();
    else     model_reset();
    #1;
    check_all(pfx);
  endtask

  task automatic rand_data();
    reg_write_in  = 1'($urandom); mem_to_reg_in = 1'($urandom);
    branch_in     = 1'($urandom); mem_read_in   = 1'($urandom);
    mem_write_in  = 1'($urandom); alu_src_in    = 1'($urandom);
    reg_dst_in    = 1'($urandom); alu_op_in     = 2'($urandom_range(0, 2));
    pc_4_in       = $urandom;     rd_data_1_in  = $urandom;
    rd_data_2_in  = $urandom;     sign_ext_in   = $urandom;
    rs_in         = 5'($urandom); rt_in         = 5'($urandom);
    rd_in         = 5'($urandom);
  endtask

  logic [31:0] saved_rd2;

  initial begin
    rst = 1'b1; stall = 0; flush = 0; valid_in = 0; cnt_clr = 0;
    rand_data();
    #2 rst = 1'b0;
    #1 model_reset();
    check_all("rst_async");
    step("rst_hold");
    step("rst_hold2");

    // Release between edges; first edge loads pc_4 = 4.
    valid_in = 1; pc_4_in = 32'h0000_0004;
    rst = 1'b1;
    step("first_load");
    check("first_pc4", pc_4_out, 32'h0000_0004);

    // Non-zero inputs, then an async reset pulse between edges.
    rand_data(); valid_in = 1; stall = 1; cnt_clr = 0;
    step("pre_rst");
    stall = 0; flush = 1;
    #1 rst = 1'b0;
    #1 model_reset();
    check_all("rst_pulse");
    check("rst_pulse_pc4", pc_4_out, 32'd0);
    rst = 1'b1; flush = 0;

    // Directed load of a valid instruction; counters cleared together.
    rand_data(); valid_in = 1; reg_write_in = 1; alu_op_in = 2'd2;
    rs_in = 5'd8; rt_in = 5'd9; rd_in = 5'd10; rd_data_1_in = 32'hDEAD_BEEF;
    cnt_clr = 1;
    step("load");
    check("load_rd1", rd_data_1_out, 32'hDEAD_BEEF);
    check("load_idx", {rs_out, rt_out, rd_out}, {5'd8, 5'd9, 5'd10});
    check("load_aluop", alu_op_out, 2'd2);
    check("load_rw", reg_write_out, 1'b1);
    check("load_valid", valid_out, 1'b1);
    cnt_clr = 0;

    // Stall 3 cycles while inputs change.
    for (int i = 0; i < 3; i++) begin
      rand_data(); stall = 1;
      step("stall");
    end
    check("stall_rd1", rd_data_1_out, 32'hDEAD_BEEF);
    check("stall_rs", rs_out, 5'd8);
    check("stall_cnt3", stall_cnt, 4'd3);
    check("stall_bcnt", bubble_cnt, 4'd0);

    // Flush with stall asserted (load-use bubble).
    rand_data(); valid_in = 1; mem_read_in = 1; reg_write_in = 1; stall = 1; flush = 1;
    step("flush");
    check("flush_mr", mem_read_out, 1'b0);
    check("flush_rw", reg_write_out, 1'b0);
    check("flush_idx", {rs_out, rt_out, rd_out}, 15'd0);
    check("flush_valid", valid_out, 1'b0);
    check("flush_bcnt", bubble_cnt, 4'd1);
    check("flush_scnt", stall_cnt, 4'd3);
    stall = 0; flush = 0;

    // Load of a non-valid slot: controls gated, data still loads.
    rand_data(); valid_in = 0; reg_write_in = 1; mem_write_in = 1;
    saved_rd2 = rd_data_2_in;
    step("gated");
    check("gated_rw", reg_write_out, 1'b0);
    check("gated_mw", mem_write_out, 1'b0);
    check("gated_rd2", rd_data_2_out, saved_rd2);
    check("gated_bcnt", bubble_cnt, 4'd2);

    // Saturation of stall_cnt, then clear overriding an increment.
    valid_in = 1; stall = 1;
    for (int i = 0; i < 20; i++) begin
      rand_data();
      step("sat");
    end
    check("sat_scnt", stall_cnt, 4'd15);
    cnt_clr = 1;
    step("sat_clr");
    check("sat_clr_scnt", stall_cnt, 4'd0);
    cnt_clr = 0; stall = 0;

    // Random traffic with occasional async reset pulses.
    for (int i = 0; i < 400; i++) begin
      rand_data();
      valid_in = ($urandom_range(0, 3) != 0);
      stall    = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 4) == 0);
      cnt_clr  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b0;
        #1 model_reset();
        check_all("rnd_rst");
        if ($urandom_range(0, 1) == 1) begin
          rst = 1'b1;
        end
      end
      step("rnd");
      rst = 1'b1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
